edge_event_capture: RTL

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

---
 rtl/edge_event_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/edge_event_capture.sv
// -----------------------------------------------------------------------------
// edge_event_capture
//
// Purpose:
//   Multi-channel edge detector.
//   - Each input level is synchronised through an optional flop chain.
//   - Edges are then detected against a one-cycle history flop.
//   - Each detected edge produces:
//       * a registered one-cycle strobe,
//       * a sticky "event seen" flag,
//       * a saturating event counter.
//   - An interrupt is raised when any sticky flag is set on an enabled channel.
//
// Parameters:
//   N_CH        number of independent channels (1..32)
//   SYNC_STAGES synchroniser depth per channel (0 = none, 0..4)
//   CNT_W       per-channel counter width (1..16)
//
// Ports:
//   i_clk     clock, rising edge active
//   i_rst_n   asynchronous active-low reset
//   i_data    [N_CH]         monitored levels
//   i_mode    [2*N_CH]       per-channel edge select {fall_en, rise_en}
//   i_clr     [N_CH]         synchronous clear of sticky flag and counter
//   i_irq_en  [N_CH]         per-channel interrupt enable
//   o_pulse   [N_CH]         one-cycle event strobe
//   o_sticky  [N_CH]         event-seen flag
//   o_count   [N_CH*CNT_W]   saturating counts, channel c at [c*CNT_W +: CNT_W]
//   o_irq                    OR of (o_sticky & i_irq_en)
// -----------------------------------------------------------------------------
module edge_event_capture #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_data,
  input  logic [2*N_CH-1:0]       i_mode,
  input  logic [N_CH-1:0]         i_clr,
  input  logic [N_CH-1:0]         i_irq_en,
  output logic [N_CH-1:0]         o_pulse,
  output logic [N_CH-1:0]         o_sticky,
  output logic [N_CH*CNT_W-1:0]   o_count,
  output logic                    o_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             s;
      logic             h_q;
      logic             detect;
      logic             pulse_q;
      logic             sticky_q;
      logic             sticky_d;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign s = i_data[gi];
      end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            sync_q <= '0;
          end else begin
            sync_q[0] <= i_data[gi];
            for (int i = 1; i < SYNC_STAGES; i++) begin
              sync_q[i] <= sync_q[i-1];
            end
          end
        end

        assign s = sync_q[SYNC_STAGES-1];
      end

      // Mode is applied combinationally, so a change of mode immediately
      // re-evaluates whatever edge is currently sitting between s and h.
      assign detect = (s & ~h_q & i_mode[2*gi])
                    | (~s & h_q & i_mode[2*gi+1]);

      // A clear that coincides with a detect restarts from one event,
      // so that event is not lost.
      always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (i_clr[gi]) begin
          sticky_d = detect;
          count_d  = detect ? CNT_ONE : '0;
        end else if (detect) begin
          sticky_d = 1'b1;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          h_q      <= 1'b0;
          pulse_q  <= 1'b0;
          sticky_q <= 1'b0;
          count_q  <= '0;
        end else begin
          h_q      <= s;
          pulse_q  <= detect;
          sticky_q <= sticky_d;
          count_q  <= count_d;
        end
      end

      assign o_pulse[gi]                 = pulse_q;
      assign o_sticky[gi]                = sticky_q;
      assign o_count[gi*CNT_W +: CNT_W]  = count_q;
    end
  endgenerate

  assign o_irq = |(o_sticky & i_irq_en);

endmodule
